f_ifetch_ctrl: RTL and testbench
================================

// Module: f_ifetch_ctrl
// PURPOSE
//  F-stage fetch controller between F_PC and the F/D pipeline register.
//  Issues one-outstanding requests to a variable-latency instruction memory at pc_i,
//  advances the PC via pc_en_o, and queues {instr, pc, exc} in a DEPTH-entry FIFO.
//  Presents the FIFO head to D with valid/ready; flush_i discards queued and in-flight fetches.
// PARAMETERS
//  DEPTH    2             FIFO entries; power of two, >=2
//  IM_BASE  32'h0000_3000 lowest legal fetch address
//  IM_TOP   32'h0000_6FFC highest legal fetch address
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  pc_i         in   32  current PC from F_PC
//  pc_en_o      out  1   enable to F_PC: load NPC at next edge
//  im_req_o     out  1   one-cycle fetch request strobe
//  im_addr_o    out  32  fetch address (= pc_i when im_req_o)
//  im_rvalid_i  in   1   response valid, >=1 cycle after request
//  im_rdata_i   in   32  instruction word
//  flush_i      in   1   redirect: drop FIFO and in-flight fetch
//  out_ready_i  in   1   D stage accepts (= !stall)
//  out_valid_o  out  1   FIFO non-empty
//  out_instr_o  out  32  head instruction (0 when empty)
//  out_pc_o     out  32  head PC (0 when empty)
//  out_exc_o    out  5   head exc code: 0 none, 4 AdEL (0 when empty)
// BEHAVIOUR
//  Reset: state IDLE, count/rd_ptr/wr_ptr 0; all outputs 0 while reset=1.
//  legal = pc_i[1:0]==0 && IM_BASE<=pc_i<=IM_TOP.
//  pc_en_o, im_req_o, im_addr_o: combinational from state, count, pc_i, flush_i.
//  FSM IDLE:
//   - flush_i: no request; pc_en_o=1 (F_PC loads redirect NPC); FIFO cleared.
//   - else if count<DEPTH && legal: im_req_o=1, im_addr_o=pc_i, pc_en_o=1;
//     latch req_pc=pc_i; ->WAIT.
//   - else if count<DEPTH && !legal: no request; push {0, pc_i, 4}; pc_en_o=1; stay IDLE.
//   - else (full): im_req_o=0, pc_en_o=0.
//   - im_rvalid_i in IDLE is ignored.
//  WAIT: pc_en_o=0, im_req_o=0, except pc_en_o=1 while flush_i=1.
//   - rvalid && !flush: push {im_rdata_i, req_pc, 0}; ->IDLE.
//   - rvalid && flush: data dropped; FIFO cleared; ->IDLE.
//   - !rvalid && flush: FIFO cleared; ->DRAIN.
//  DRAIN: pc_en_o=0 unless flush_i; no request; rvalid -> discard, ->IDLE; further flush_i re-clears FIFO.
//  Next request issues the cycle after returning to IDLE (max 1 fetch / 2 cycles).
//  No overflow: a request needs count<DEPTH and only that response pushes.
//  FIFO:
//   - pop when out_valid_o && out_ready_i; push+pop same cycle leaves count unchanged.
//   - Pointers wrap mod DEPTH; order strictly preserved.
//   - flush_i clears the FIFO (overrides push/pop); head outputs read 0 next cycle.
//  Reset mid-WAIT/DRAIN: ->IDLE; a late rvalid after reset lands in IDLE and is ignored.
// TESTING
//  1 pc_i=0x3000, latency 1, rdata=0x24080001, ready=1 -> im_req_o cycle 1;
//    out_valid_o=1 with instr 0x24080001, pc 0x3000, exc 0.
//  2 ready=0, 3 fetches -> count=2, im_req_o=0, pc_en_o=0;
//    ready=1 -> pops in order 0x3000, 0x3004; fetch of 0x3008 resumes.
//  3 pc_i=0x3002, then 0x7000 -> no im_req_o; entries {0, 0x3002, 4}, {0, 0x7000, 4}.
//  4 latency 3, flush_i cycle after request -> DRAIN, response discarded, FIFO empty;
//    next request at redirect PC 0x4180.
//  5 flush_i coincident with im_rvalid_i -> no push, state IDLE, out_valid_o=0.
//  6 reset in WAIT, rvalid 1 cycle later -> ignored; count 0, outputs 0.

Source files
------------

// File: rtl/f_ifetch_ctrl.sv
// f_ifetch_ctrl: F-stage fetch controller.
// Issues one outstanding instruction-memory request at a time for the PC held in F_PC.
// It advances F_PC and queues {instr, pc, exc} in a small FIFO that feeds the D stage.
// Out-of-range or misaligned PCs are not fetched; they queue an AdEL entry (exc 4) instead.
// A flush drops everything queued and forgets the in-flight fetch.
// If a response for a dropped fetch is still on its way, DRAIN absorbs it.
module f_ifetch_ctrl #(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] IM_BASE = 32'h0000_3000,
    parameter logic [31:0] IM_TOP  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic        pc_en_o,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_rvalid_i,
    input  logic [31:0] im_rdata_i,
    input  logic        flush_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [4:0]  out_exc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t        state;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [4:0]    fifo_exc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          legal;
    logic          not_full;
    logic          pc_en;
    logic          req;
    logic          push;
    logic          pop;
    logic [31:0]   push_instr;
    logic [31:0]   push_pc;
    logic [4:0]    push_exc;

    assign legal    = (pc_i[1:0] == 2'b00) && (pc_i >= IM_BASE) && (pc_i <= IM_TOP);
    assign not_full = (count < DEPTH_C);
    assign pop      = (count != '0) && out_ready_i;

    // Decide this cycle's PC advance, fetch request and FIFO push from the fetch state
    always_comb begin
        pc_en      = 1'b0;
        req        = 1'b0;
        push       = 1'b0;
        push_instr = 32'h0;
        push_pc    = 32'h0;
        push_exc   = EXC_NONE;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    pc_en = 1'b1;
                end else if (not_full) begin
                    pc_en = 1'b1;
                    if (legal) begin
                        req = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_pc  = pc_i;
                        push_exc = EXC_ADEL;
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    pc_en = 1'b1;
                end else if (im_rvalid_i) begin
                    push       = 1'b1;
                    push_instr = im_rdata_i;
                    push_pc    = req_pc;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    pc_en = 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    assign pc_en_o   = pc_en & ~reset;
    assign im_req_o  = req & ~reset;
    assign im_addr_o = (req & ~reset) ? pc_i : 32'h0;

    // Fetch state: wait for the single outstanding response, or drain one that a flush orphaned
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_pc <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush_i && not_full && legal) begin
                        req_pc <= pc_i;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (im_rvalid_i) begin
                        state <= IDLE;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (im_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping: flush empties the queue and takes priority over push and pop
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: write the new entry at the tail
    always_ff @(posedge clk) begin
        if (!reset && !flush_i && push) begin
            fifo_instr[wr_ptr] <= push_instr;
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_exc[wr_ptr]   <= push_exc;
        end
    end

    assign out_valid_o = (count != '0) && !reset;
    assign out_instr_o = out_valid_o ? fifo_instr[rd_ptr] : 32'h0;
    assign out_pc_o    = out_valid_o ? fifo_pc[rd_ptr]    : 32'h0;
    assign out_exc_o   = out_valid_o ? fifo_exc[rd_ptr]   : 5'h0;

endmodule

// File: tb/tb_f_ifetch_ctrl.sv
// tb_f_ifetch_ctrl: directed scenarios plus a randomized run against an in-order fetch-stream model.
// The bench plays F_PC (pc + 4, or the redirect target on flush) and a variable-latency instruction memory.
module tb_f_ifetch_ctrl;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] IM_BASE = 32'h0000_3000;
    localparam logic [31:0] IM_TOP  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_rvalid_i;
    logic [31:0] im_rdata_i;
    logic        flush_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [4:0]  out_exc_o;

    f_ifetch_ctrl #(.DEPTH(DEPTH), .IM_BASE(IM_BASE), .IM_TOP(IM_TOP)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_en_o(pc_en_o),
        .im_req_o(im_req_o), .im_addr_o(im_addr_o), .im_rvalid_i(im_rvalid_i),
        .im_rdata_i(im_rdata_i), .flush_i(flush_i), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
        .out_exc_o(out_exc_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
    } entry_t;

    entry_t      exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] pc_reg;
    logic [31:0] redirect_pc;
    logic        mem_busy;
    int          mem_left;
    logic [31:0] mem_addr;
    int          lat_cfg;

    logic        s_req, s_pc_en, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [4:0]  s_exc;

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IM_BASE) && (a <= IM_TOP);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2408_0001 + (a - 32'h0000_3000);
    endfunction

    // Present this cycle's inputs (F_PC value, memory response) and sample the DUT before the edge
    task automatic drive();
        pc_i = pc_reg;
        if (mem_busy && mem_left == 0) begin
            im_rvalid_i = 1'b1;
            im_rdata_i  = mem_word(mem_addr);
        end else begin
            im_rvalid_i = 1'b0;
            im_rdata_i  = $urandom;
        end
        #1;
        s_req   = im_req_o;
        s_pc_en = pc_en_o;
        s_addr  = im_addr_o;
        s_valid = out_valid_o;
        s_instr = out_instr_o;
        s_pc    = out_pc_o;
        s_exc   = out_exc_o;
    endtask

    // Clock edge, then update the memory and F_PC stand-ins from what was sampled
    task automatic advance();
        @(posedge clk);
        #1;
        if (mem_busy) begin
            if (mem_left == 0) mem_busy = 1'b0;
            else mem_left = mem_left - 1;
        end
        if (s_req) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_left = ((lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg) - 1;
        end
        if (s_pc_en) pc_reg = flush_i ? redirect_pc : pc_reg + 32'd4;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset       = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        redirect_pc = 32'h0;
        mem_busy    = 1'b0;
        mem_left    = 0;
        lat_cfg     = 1;
        pc_reg      = start_pc;
        exp_q.delete();
        drive();
        advance();
        drive();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(32'h3000);
        reset = 1'b1;
        out_ready_i = 1'b1;
        drive();
        tests++; if ({s_req, s_pc_en, s_valid} !== 3'b000) begin fails++; $display("[TB] FAIL reset_ctrl: got req/pc_en/valid %b expected 000", {s_req, s_pc_en, s_valid}); end
        tests++; if ({s_addr, s_instr, s_pc, s_exc} !== 101'h0) begin fails++; $display("[TB] FAIL reset_data: got addr %h instr %h pc %h exc %h expected all 0", s_addr, s_instr, s_pc, s_exc); end
        advance();
        reset = 1'b0;
        out_ready_i = 1'b0;
        drive();
        tests++; if (s_valid !== 1'b0 || s_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_empty: got valid %b instr %h expected 0 0", s_valid, s_instr); end
        advance();
    endtask

    task automatic test_single_fetch();
        do_reset(32'h3000);
        out_ready_i = 1'b1;
        drive();
        tests++; if (s_req !== 1'b1 || s_addr !== 32'h3000 || s_pc_en !== 1'b1) begin fails++; $display("[TB] FAIL first_req: got req %b addr %h pc_en %b expected 1 00003000 1", s_req, s_addr, s_pc_en); end
        advance();
        drive();
        tests++; if (s_req !== 1'b0 || s_pc_en !== 1'b0) begin fails++; $display("[TB] FAIL wait_quiet: got req %b pc_en %b expected 0 0", s_req, s_pc_en); end
        advance();
        drive();
        tests++; if (s_valid !== 1'b1 || s_instr !== 32'h2408_0001 || s_pc !== 32'h3000 || s_exc !== 5'd0) begin fails++; $display("[TB] FAIL first_entry: got v %b instr %h pc %h exc %0d expected 1 24080001 00003000 0", s_valid, s_instr, s_pc, s_exc); end
        advance();
    endtask

    task automatic test_backpressure();
        do_reset(32'h3000);
        for (int i = 0; i < 4; i++) begin
            drive();
            advance();
        end
        drive();
        tests++; if (s_req !== 1'b0 || s_pc_en !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h3000) begin fails++; $display("[TB] FAIL full_stall: got req %b pc_en %b valid %b pc %h expected 0 0 1 00003000", s_req, s_pc_en, s_valid, s_pc); end
        advance();
        drive();
        tests++; if (s_req !== 1'b0 || s_pc_en !== 1'b0) begin fails++; $display("[TB] FAIL full_hold: got req %b pc_en %b expected 0 0", s_req, s_pc_en); end
        advance();
        out_ready_i = 1'b1;
        drive();
        tests++; if (s_pc !== 32'h3000 || s_req !== 1'b0) begin fails++; $display("[TB] FAIL pop_first: got pc %h req %b expected 00003000 0", s_pc, s_req); end
        advance();
        drive();
        tests++; if (s_pc !== 32'h3004 || s_req !== 1'b1 || s_addr !== 32'h3008) begin fails++; $display("[TB] FAIL pop_second: got pc %h req %b addr %h expected 00003004 1 00003008", s_pc, s_req, s_addr); end
        advance();
    endtask

    task automatic test_illegal();
        do_reset(32'h3002);
        drive();
        tests++; if (s_req !== 1'b0 || s_pc_en !== 1'b1) begin fails++; $display("[TB] FAIL misaligned_nofetch: got req %b pc_en %b expected 0 1", s_req, s_pc_en); end
        advance();
        pc_reg = 32'h7000;
        drive();
        tests++; if (s_req !== 1'b0 || s_pc_en !== 1'b1) begin fails++; $display("[TB] FAIL range_nofetch: got req %b pc_en %b expected 0 1", s_req, s_pc_en); end
        advance();
        out_ready_i = 1'b1;
        drive();
        tests++; if (s_pc_en !== 1'b0 || s_valid !== 1'b1 || s_instr !== 32'h0 || s_pc !== 32'h3002 || s_exc !== 5'd4) begin fails++; $display("[TB] FAIL adel_first: got pc_en %b v %b instr %h pc %h exc %0d expected 0 1 0 00003002 4", s_pc_en, s_valid, s_instr, s_pc, s_exc); end
        advance();
        drive();
        tests++; if (s_valid !== 1'b1 || s_instr !== 32'h0 || s_pc !== 32'h7000 || s_exc !== 5'd4) begin fails++; $display("[TB] FAIL adel_second: got v %b instr %h pc %h exc %0d expected 1 0 00007000 4", s_valid, s_instr, s_pc, s_exc); end
        advance();
        out_ready_i = 1'b0;
    endtask

    task automatic test_flush_wait();
        do_reset(32'h3000);
        lat_cfg = 3;
        out_ready_i = 1'b1;
        drive();
        advance();
        flush_i = 1'b1;
        redirect_pc = 32'h4180;
        drive();
        tests++; if (s_pc_en !== 1'b1 || s_req !== 1'b0) begin fails++; $display("[TB] FAIL flush_wait_pcen: got pc_en %b req %b expected 1 0", s_pc_en, s_req); end
        advance();
        flush_i = 1'b0;
        drive();
        tests++; if (s_pc_en !== 1'b0 || s_req !== 1'b0) begin fails++; $display("[TB] FAIL drain_quiet: got pc_en %b req %b expected 0 0", s_pc_en, s_req); end
        advance();
        drive();
        tests++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin fails++; $display("[TB] FAIL drain_discard: got valid %b req %b expected 0 0", s_valid, s_req); end
        advance();
        drive();
        tests++; if (s_req !== 1'b1 || s_addr !== 32'h4180 || s_valid !== 1'b0) begin fails++; $display("[TB] FAIL redirect_req: got req %b addr %h valid %b expected 1 00004180 0", s_req, s_addr, s_valid); end
        advance();
    endtask

    task automatic test_flush_rvalid();
        do_reset(32'h3000);
        lat_cfg = 2;
        out_ready_i = 1'b1;
        drive();
        advance();
        drive();
        advance();
        flush_i = 1'b1;
        redirect_pc = 32'h5000;
        drive();
        tests++; if (im_rvalid_i !== 1'b1 || s_pc_en !== 1'b1) begin fails++; $display("[TB] FAIL flush_rvalid_pcen: got rvalid %b pc_en %b expected 1 1", im_rvalid_i, s_pc_en); end
        advance();
        flush_i = 1'b0;
        drive();
        tests++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h5000) begin fails++; $display("[TB] FAIL flush_rvalid_drop: got valid %b req %b addr %h expected 0 1 00005000", s_valid, s_req, s_addr); end
        advance();
    endtask

    task automatic test_reset_in_wait();
        do_reset(32'h3000);
        drive();
        advance();
        drive();
        advance();
        lat_cfg = 2;
        drive();
        advance();
        reset = 1'b1;
        drive();
        tests++; if ({s_req, s_pc_en, s_valid} !== 3'b000 || s_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_mid_wait: got req/pc_en/valid %b pc %h expected 000 0", {s_req, s_pc_en, s_valid}, s_pc); end
        advance();
        reset = 1'b0;
        lat_cfg = 3;
        drive();
        tests++; if (im_rvalid_i !== 1'b1 || s_valid !== 1'b0 || s_instr !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h3008) begin fails++; $display("[TB] FAIL late_rvalid: got rvalid %b valid %b instr %h req %b addr %h expected 1 0 0 1 00003008", im_rvalid_i, s_valid, s_instr, s_req, s_addr); end
        advance();
        drive();
        tests++; if (s_valid !== 1'b0) begin fails++; $display("[TB] FAIL late_rvalid_nopush: got valid %b expected 0", s_valid); end
        advance();
    endtask

    // Random run: every PC that F_PC gives up without a flush must reach D exactly once, in order
    task automatic test_random();
        entry_t got;
        entry_t want;
        do_reset(32'h6FC0);
        lat_cfg = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = 32'h0000_2FFC;
                1:       redirect_pc = 32'h0000_6FF9;
                default: redirect_pc = {$urandom_range(32'h3000, 32'h6FFC)} & 32'hFFFF_FFFC;
            endcase
            drive();
            if (s_req) begin
                tests++;
                if (s_addr !== pc_i || mem_busy) begin fails++; $display("[TB] FAIL rand_req cyc %0d: got addr %h busy %b expected %h 0", cyc, s_addr, mem_busy, pc_i); end
            end
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (s_valid) begin
                    got = '{instr: s_instr, pc: s_pc, exc: s_exc};
                    want = (exp_q.size() > 0) ? exp_q[0] : '0;
                    tests++;
                    if (exp_q.size() == 0 || got !== want) begin fails++; $display("[TB] FAIL rand_head cyc %0d: got instr %h pc %h exc %0d expected instr %h pc %h exc %0d (model entries %0d)", cyc, s_instr, s_pc, s_exc, want.instr, want.pc, want.exc, exp_q.size()); end
                    if (out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (s_pc_en) begin
                    exp_q.push_back(is_legal(pc_i) ? '{instr: mem_word(pc_i), pc: pc_i, exc: 5'd0}
                                                  : '{instr: 32'h0, pc: pc_i, exc: 5'd4});
                end
            end
            tests++;
            if (exp_q.size() > DEPTH + 1) begin fails++; $display("[TB] FAIL rand_backlog cyc %0d: got %0d pending entries expected at most %0d", cyc, exp_q.size(), DEPTH + 1); end
            advance();
        end
        flush_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        im_rvalid_i = 1'b0;
        im_rdata_i = 32'h0;
        pc_i = 32'h0;
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_illegal();
        test_flush_wait();
        test_flush_rvalid();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
